// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the stream arbiter: FSM state encoding and the default
// data width / burst length used by stream_arbiter.
// -----------------------------------------------------------------------------
package stream_pkg;

  // FSM encoding kept as plain constants so legacy netlists and scripts that
  // probe the state bit keep working.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam int DEFAULT_DW        = 8;
  // Matches the 16-entry downstream buffer.
  localparam int DEFAULT_MAX_BURST = 16;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin winner selection: the lowest request index at or after ptr,
// wrapping modulo N, wins.
//
// Ports
//   req     in   N   request vector
//   ptr     in   PW  search start index (must be < N)
//   winner  out  N   one-hot winner, all-zero when no request
//   any     out  1   at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          any
);

  always_comb begin
    logic          found;
    logic [PW:0]   idx;
    // NOTE: every combinational output gets a default before any branch;
    // otherwise a path that skips the assignment infers a latch.
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit holds ptr+i before the single wrap subtraction.
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        winner[idx[PW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/stream_arbiter.sv
// -----------------------------------------------------------------------------
// stream_arbiter
// Round-robin arbiter that merges NREQ AXI-stream-like requester channels onto
// one downstream port. A grant is held for a whole packet, or until MAX_BURST
// beats have moved, after which the owner re-arbitrates for the remainder.
//
// Optional feature: define STREAM_ARB_WATCHDOG_EN to compile in a stall
// watchdog that releases an owner whose valid stays low for TIMEOUT XFER
// cycles and pulses `timeout`. Without it `timeout` is tied low.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  global enable; low blocks new grants only
//   s_tdata/tvalid/tlast  requester channels, channel i at [i*DW +: DW]
//   s_tready            per-channel ready (only the owner sees m_tready)
//   m_tdata/tvalid/tlast  downstream stream, muxed from the owner
//   m_tready            downstream ready
//   op_en               en delayed by one cycle
//   grant               one-hot owner, zero when idle
//   busy                high while a grant is held
//   timeout             one-cycle pulse on watchdog release
// -----------------------------------------------------------------------------
module stream_arbiter
  import stream_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = DEFAULT_DW,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ*DW-1:0] s_tdata,
  input  logic [NREQ-1:0]  s_tvalid,
  input  logic [NREQ-1:0]  s_tlast,
  output logic [NREQ-1:0]  s_tready,
  output logic [DW-1:0]    m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             op_en,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic             timeout
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("stream_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("stream_arbiter: TIMEOUT must be at least 1");
  end

  logic [0:0]      r_state;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_rr_ptr;
  logic [BW-1:0]   r_burst_cnt;
  logic            r_op_en;
  logic            r_run;

  logic [NREQ-1:0] w_win;
  logic            w_any;
  logic [PW-1:0]   w_gidx;
  logic [PW-1:0]   w_next_ptr;
  logic            w_beat;
  logic            w_burst_done;
  logic            w_wd_fire;
  logic            w_release;

  rr_pick #(.N(NREQ), .PW(PW)) u_rr_pick (
    .req    (s_tvalid),
    .ptr    (r_rr_ptr),
    .winner (w_win),
    .any    (w_any)
  );

  // Index of the current owner, used only to advance the pointer on release.
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (r_grant[i]) w_gidx = PW'(i);
  end

  assign w_next_ptr = (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + 1'b1;

  // grant is all-zero in IDLE, so every masked output below collapses to its
  // idle value without consulting the state, including during reset.
  always_comb begin
    m_tdata = '0;
    for (int i = 0; i < NREQ; i++)
      if (r_grant[i]) m_tdata = s_tdata[i*DW +: DW];
  end

  assign m_tvalid = |(r_grant & s_tvalid);
  assign m_tlast  = |(r_grant & s_tlast);
  assign s_tready = r_grant & {NREQ{m_tready}};

  assign w_beat       = m_tvalid & m_tready;
  assign w_burst_done = (r_burst_cnt == BW'(MAX_BURST - 1));
  assign w_release    = (w_beat & (m_tlast | w_burst_done)) | w_wd_fire;

`ifdef STREAM_ARB_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT) + 1;

  logic [SW-1:0] r_stall_cnt;
  logic          r_timeout;
  logic          w_stall;

  assign w_stall   = (r_state == ST_XFER) & ~m_tvalid;
  assign w_wd_fire = w_stall & (r_stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= w_wd_fire;
      // Any valid from the owner (or leaving XFER) restarts the count.
      if (w_stall && !w_wd_fire) r_stall_cnt <= r_stall_cnt + 1'b1;
      else                       r_stall_cnt <= '0;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wd_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_op_en     <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_op_en <= en;
      // Reset release is taken through this flop, so the first grant can
      // happen no earlier than the second edge after deassertion.
      r_run   <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_run && en && w_any) begin
            r_state     <= ST_XFER;
            r_grant     <= w_win;
            r_burst_cnt <= '0;
          end
        end
        ST_XFER: begin
          if (w_release) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= w_next_ptr;
          end else if (w_beat) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state == ST_XFER);
  assign op_en = r_op_en;

endmodule
